// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes pulse widths into 24-bit pixels and latches whole frames.
// Optional macro WS2812_RX_ERR_EN adds pulse-width and partial-pixel error reporting on err.
module ws2812_rx #(
    parameter int CLK_FRE    = 50_000_000,
    parameter int BIT_THRESH = 31,
    parameter int MIN_HIGH   = 4,
    parameter int MAX_HIGH   = 75,
    parameter int RESET_LOW  = 2500,
    parameter int MAX_PIXELS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     din,
    output logic [23:0]              pixel_data,
    output logic                     pixel_valid,
    output logic [7:0]               pixel_index,
    output logic                     frame_done,
    output logic [7:0]               frame_pixels,
    output logic [24*MAX_PIXELS-1:0] led_frame,
    output logic                     busy,
    output logic                     err
);
    localparam int CW = $clog2(RESET_LOW + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RESET_LOW);
    localparam logic [CW-1:0] GAP_LAST = CW'(RESET_LOW - 1);

    typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

    state_t                    state, state_n;
    logic                      din_m, din_s, din_q;
    logic                      rise, fall;
    logic [CW-1:0]             cnt;
    logic                      start, bit_ev, frame_end, abort, bit_val;
    logic [23:0]               shreg, px;
    logic [4:0]                bit_cnt;
    logic [7:0]                pix_cnt;
    logic [24*MAX_PIXELS-1:0]  shadow;
    logic                      unused_cfg;

    assign unused_cfg = ^{CLK_FRE, MIN_HIGH, MAX_HIGH};

    assign rise    = din_s & ~din_q;
    assign fall    = ~din_s & din_q;
    assign bit_val = (cnt >= CW'(BIT_THRESH));
    assign px      = {bit_val, shreg[23:1]};

    // cnt holds the run length of din_q's level, so on a falling edge it equals the high width
    always_ff @(posedge clk) begin
        if (reset) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
            din_q <= 1'b0;
            cnt   <= '0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_q <= din_s;
            if (rise | fall)
                cnt <= CW'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        bit_ev    = 1'b0;
        frame_end = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE:  if (!din_s && !din_q && cnt >= GAP_LAST) state_n = ARMED;
            ARMED: if (rise) begin
                       start   = 1'b1;
                       state_n = HIGH;
                   end
            HIGH:  if (fall) begin
`ifdef WS2812_RX_ERR_EN
                       if (cnt < CW'(MIN_HIGH) || cnt > CW'(MAX_HIGH)) begin
                           abort   = 1'b1;
                           state_n = IDLE;
                       end else
`endif
                       begin
                           bit_ev  = 1'b1;
                           state_n = LOW;
                       end
                   end
            // a rise landing on the gap's final cycle still closes the frame and is dropped
            LOW:   if (cnt >= GAP_LAST) begin
                       frame_end = 1'b1;
                       state_n   = ARMED;
                   end else if (rise) begin
                       state_n = HIGH;
                   end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            shadow       <= '0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            pixel_index  <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            led_frame    <= '0;
            busy         <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (start) begin
                bit_cnt <= '0;
                pix_cnt <= '0;
                shadow  <= '0;
                busy    <= 1'b1;
            end
            if (bit_ev) begin
                shreg <= px;
                if (bit_cnt == 5'd23) begin
                    bit_cnt     <= '0;
                    pixel_data  <= px;
                    pixel_valid <= 1'b1;
                    pixel_index <= pix_cnt;
                    for (int k = 0; k < MAX_PIXELS; k++)
                        if (pix_cnt == 8'(k)) shadow[24*k +: 24] <= px;
                    if (pix_cnt != 8'hFF) pix_cnt <= pix_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (frame_end) begin
                frame_done   <= 1'b1;
                led_frame    <= shadow;
                frame_pixels <= pix_cnt;
                busy         <= 1'b0;
            end
            if (abort) busy <= 1'b0;
        end
    end

`ifdef WS2812_RX_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) err <= 1'b0;
        else       err <= abort | (frame_end & (bit_cnt != 5'd0));
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus pushes expected pixels/frames, a negedge monitor checks them.
// Expectations follow the WS2812_RX_ERR_EN macro when it is defined for the build.
module tb_ws2812_rx;
    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                din = 1'b0;
    logic [23:0]         pixel_data;
    logic                pixel_valid;
    logic [7:0]          pixel_index;
    logic                frame_done;
    logic [7:0]          frame_pixels;
    logic [119:0]        led_frame;
    logic                busy;
    logic                err;

`ifdef WS2812_RX_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    typedef struct { logic [23:0] data; logic [7:0] idx; } pix_t;
    typedef struct { logic [7:0] n; logic [119:0] frame; logic e; } frm_t;

    pix_t pq[$];
    frm_t fq[$];
    pix_t mp;
    frm_t mf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int err_abort = 0;
    logic [23:0] pat;

    ws2812_rx dut (
        .clk(clk), .reset(reset), .din(din),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
        .frame_done(frame_done), .frame_pixels(frame_pixels), .led_frame(led_frame),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        last_fall = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(42, 20);
        else   pulse(20, 42);
    endtask

    task automatic send_pix(input logic [23:0] v, input int idx);
        pq.push_back('{data: v, idx: 8'(idx)});
        for (int i = 0; i < 24; i++) send_bit(v[i]);
    endtask

    task automatic exp_frame(input int n, input logic [119:0] f, input logic e);
        fq.push_back('{n: 8'(n), frame: f, e: e});
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (pixel_valid) begin
            if (pq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pixel: got idx %0d data %h, expected none", pixel_index, pixel_data);
            end else begin
                mp = pq.pop_front();
                chk("pixel_data", pixel_data, mp.data);
                chk("pixel_index", pixel_index, mp.idx);
                chk("pixel_latency", cyc - last_fall, 3);
            end
        end
        if (frame_done) begin
            if (fq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame_done: got frame_pixels %0d, expected none", frame_pixels);
            end else begin
                mf = fq.pop_front();
                chk("frame_pixels", frame_pixels, mf.n);
                chk("led_frame", led_frame, mf.frame);
                chk("frame_err", err, mf.e);
                chk("frame_latency", cyc - last_fall, 2502);
            end
        end
        if (err && !frame_done) begin
`ifdef WS2812_RX_ERR_EN
            err_abort++;
`else
            checks++; errors++;
            $display("FAIL unexpected_err: got 1 expected 0");
`endif
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_led_frame", led_frame, 120'h0);
        chk("reset_outputs", {pixel_data, pixel_valid, pixel_index, frame_done, frame_pixels, busy, err}, 0);
        reset = 1'b0;
        gap(2600);

        // driver-timed five-pixel frame
        send_pix(24'h000008, 0);
        chk("busy_mid_frame", busy, 1);
        send_pix(24'h000808, 1);
        send_pix(24'h000808, 2);
        send_pix(24'h080808, 3);
        send_pix(24'h200000, 4);
        exp_frame(5, 120'h200000_080808_000808_000808_000008, 1'b0);
        gap(14000);
        chk("busy_after_frame", busy, 0);

        // 30-clock highs decode 0, 31-clock highs decode 1
        pat = 24'hA5A5A5;
        pq.push_back('{data: pat, idx: 8'd0});
        for (int i = 0; i < 24; i++) pulse(pat[i] ? 31 : 30, 30);
        exp_frame(1, {96'h0, pat}, 1'b0);
        gap(3000);

        // two pixels plus a 10-bit tail
        send_pix(24'hABCDEF, 0);
        send_pix(24'h123456, 1);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        exp_frame(2, {72'h0, 24'h123456, 24'hABCDEF}, ERR_ON);
        gap(3000);

        // seven pixels, only five stored
        for (int k = 0; k < 7; k++) send_pix(24'(24'h111111 * (k + 1)), k);
        exp_frame(7, 120'h555555_444444_333333_222222_111111, 1'b0);
        gap(3000);

        // 100-clock high as bit 5 of the second pixel
        send_pix(24'h0F0F0F, 0);
        pat = 24'h5A5A3F;
`ifndef WS2812_RX_ERR_EN
        pq.push_back('{data: pat, idx: 8'd1});
        exp_frame(2, {72'h0, pat, 24'h0F0F0F}, 1'b0);
`endif
        for (int i = 0; i < 24; i++) begin
            if (i == 5) pulse(100, 42);
            else        send_bit(pat[i]);
        end
        gap(3000);
`ifdef WS2812_RX_ERR_EN
        chk("abort_err_count", err_abort, 1);
        chk("abort_led_frame_kept", led_frame, 120'h555555_444444_333333_222222_111111);
        chk("abort_frame_pixels_kept", frame_pixels, 7);
        chk("abort_busy", busy, 0);
`endif
        send_pix(24'h123456, 0);
        exp_frame(1, {96'h0, 24'h123456}, 1'b0);
        gap(3000);

        // reset while din is high mid-pixel
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        din = 1'b1;
        repeat (10) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_led_frame", led_frame, 120'h0);
        chk("midreset_outputs", {pixel_data, pixel_valid, pixel_index, frame_done, frame_pixels, busy, err}, 0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 30; i++) send_bit(1'b1);
        chk("busy_ignored_bits", busy, 0);
        gap(2600);
        send_pix(24'h00FF00, 0);
        exp_frame(1, {96'h0, 24'h00FF00}, 1'b0);
        gap(3000);

        chk("pixel_queue_drained", pq.size(), 0);
        chk("frame_queue_drained", fq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
